// File: rtl/mem_access_unit.sv
// Registered memory access unit: arbitrates fetch and load/store channels
// onto one ready/valid bus with lane steering, extension and timeout.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [31:0]           fetch_data,
  output logic                  fetch_err,
  input  logic                  data_req,
  input  logic                  data_store,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [1:0]            data_len,
  input  logic                  data_unsigned,
  input  logic [31:0]           data_wdata,
  output logic                  data_ack,
  output logic [31:0]           data_rdata,
  output logic                  data_err,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int CW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  owner_q;
  logic [1:0]            len_q;
  logic                  uns_q;
  logic [1:0]            lane_q;
  logic [CW-1:0]         cnt_q;
  logic                  mem_valid_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_wstrb_q;
  logic [31:0]           mem_wdata_q;
  logic                  fetch_ack_q;
  logic                  fetch_err_q;
  logic [31:0]           fetch_data_q;
  logic                  data_ack_q;
  logic                  data_err_q;
  logic [31:0]           data_rdata_q;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_len;
  logic                  sel_store;
  logic [1:0]            sel_lane;
  logic                  sel_bad;
  logic [3:0]            wstrb_d;
  logic [31:0]           wdata_d;
  logic [31:0]           shifted;
  logic [31:0]           ext_d;

  // Data channel wins; fetch is always an aligned word read.
  always_comb begin
    sel_addr  = data_req ? data_addr : fetch_addr;
    sel_len   = data_req ? data_len : 2'd3;
    sel_store = data_req & data_store;
    sel_lane  = sel_addr[1:0];
    sel_bad   = 1'b0;
    case (sel_len)
      2'd0:    sel_bad = 1'b0;
      2'd1:    sel_bad = sel_addr[0];
      2'd2:    sel_bad = 1'b1;
      default: sel_bad = |sel_addr[1:0];
    endcase
  end

  always_comb begin
    wstrb_d = 4'h0;
    wdata_d = 32'h0;
    if (sel_store) begin
      case (sel_len)
        2'd0: begin
          wstrb_d = 4'b0001 << sel_lane;
          wdata_d = {4{data_wdata[7:0]}};
        end
        2'd1: begin
          wstrb_d = 4'b0011 << sel_lane;
          wdata_d = {2{data_wdata[15:0]}};
        end
        default: begin
          wstrb_d = 4'hF;
          wdata_d = data_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    ext_d   = shifted;
    case (len_q)
      2'd0: ext_d = uns_q ? {24'h0, shifted[7:0]}
                          : {{24{shifted[7]}}, shifted[7:0]};
      2'd1: ext_d = uns_q ? {16'h0, shifted[15:0]}
                          : {{16{shifted[15]}}, shifted[15:0]};
      default: ext_d = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      len_q        <= 2'd0;
      uns_q        <= 1'b0;
      lane_q       <= 2'd0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'h0;
      mem_wdata_q  <= 32'h0;
      fetch_ack_q  <= 1'b0;
      fetch_err_q  <= 1'b0;
      fetch_data_q <= 32'h0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (data_req | fetch_req) begin
            owner_q <= data_req;
            len_q   <= sel_len;
            uns_q   <= data_req & data_unsigned;
            lane_q  <= sel_lane;
            cnt_q   <= '0;
            if (sel_bad) begin
              state_q <= S_DONE;
              if (data_req) begin
                data_ack_q   <= 1'b1;
                data_err_q   <= 1'b1;
                data_rdata_q <= 32'h0;
              end else begin
                fetch_ack_q  <= 1'b1;
                fetch_err_q  <= 1'b1;
                fetch_data_q <= 32'h0;
              end
            end else begin
              state_q     <= S_BUS;
              mem_valid_q <= 1'b1;
              mem_write_q <= sel_store;
              mem_addr_q  <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wstrb_q <= wstrb_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_BUS: begin
          if (mem_ready) begin
            state_q     <= S_DONE;
            mem_valid_q <= 1'b0;
            mem_write_q <= 1'b0;
            if (owner_q) begin
              data_ack_q   <= 1'b1;
              data_err_q   <= 1'b0;
              data_rdata_q <= mem_write_q ? 32'h0 : ext_d;
            end else begin
              fetch_ack_q  <= 1'b1;
              fetch_err_q  <= 1'b0;
              fetch_data_q <= mem_rdata;
            end
          end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
            state_q     <= S_DONE;
            mem_valid_q <= 1'b0;
            mem_write_q <= 1'b0;
            if (owner_q) begin
              data_ack_q   <= 1'b1;
              data_err_q   <= 1'b1;
              data_rdata_q <= 32'h0;
            end else begin
              fetch_ack_q  <= 1'b1;
              fetch_err_q  <= 1'b1;
              fetch_data_q <= 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          fetch_ack_q <= 1'b0;
          data_ack_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_ack  = fetch_ack_q;
  assign fetch_err  = fetch_err_q;
  assign fetch_data = fetch_data_q;
  assign data_ack   = data_ack_q;
  assign data_err   = data_err_q;
  assign data_rdata = data_rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small wait-state bus model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        data_req;
  logic        data_store;
  logic [31:0] data_addr;
  logic [1:0]  data_len;
  logic        data_unsigned;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack),
    .fetch_data(fetch_data),
    .fetch_err(fetch_err),
    .data_req(data_req),
    .data_store(data_store),
    .data_addr(data_addr),
    .data_len(data_len),
    .data_unsigned(data_unsigned),
    .data_wdata(data_wdata),
    .data_ack(data_ack),
    .data_rdata(data_rdata),
    .data_err(data_err),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int          lat, vc, acks;
  logic [31:0] res, ma, mw;
  logic        err;
  logic [3:0]  sb;

  // One request; bus raises ready after `waits` valid cycles.
  task automatic xact(input bit fch, input bit st,
                      input logic [31:0] addr, input logic [1:0] len,
                      input bit uns, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits);
    lat = 0; vc = 0; res = 0; err = 0; ma = 0; sb = 0; mw = 0;
    mem_rdata = rd;
    mem_ready = 1'b0;
    if (fch) begin
      fetch_req  = 1'b1;
      fetch_addr = addr;
    end else begin
      data_req      = 1'b1;
      data_store    = st;
      data_addr     = addr;
      data_len      = len;
      data_unsigned = uns;
      data_wdata    = wd;
    end
    for (int c = 1; c <= 20; c++) begin
      step;
      if (mem_valid) begin
        vc++;
        if (vc == 1) begin
          ma = mem_addr;
          sb = mem_wstrb;
          mw = mem_wdata;
        end
        mem_ready = (vc > waits);
      end
      if (fch ? fetch_ack : data_ack) begin
        lat = c;
        res = fch ? fetch_data : data_rdata;
        err = fch ? fetch_err : data_err;
        break;
      end
    end
    fetch_req = 1'b0;
    data_req  = 1'b0;
    mem_ready = 1'b0;
    if (lat == 0) chk("ack_bound", 32'(lat), 32'd1);
    step;
    chk("ack_pulse", 32'(fetch_ack | data_ack), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = 0;
    data_req = 1'b0; data_store = 1'b0; data_addr = 0;
    data_len = 2'd0; data_unsigned = 1'b0; data_wdata = 0;
    mem_ready = 1'b0; mem_rdata = 0;
    repeat (2) step;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_acks", 32'({fetch_ack, data_ack, fetch_err, data_err}), 32'd0);
    chk("rst_rdata", data_rdata | fetch_data, 32'd0);
    reset = 1'b0;
    step;

    xact(0, 0, 32'h100, 2'd3, 0, 0, 32'h8765_4321, 0);
    chk("wl_lat", 32'(lat), 32'd2);
    chk("wl_addr", ma, 32'h100);
    chk("wl_strb", 32'(sb), 32'd0);
    chk("wl_data", res, 32'h8765_4321);
    chk("wl_err", 32'(err), 32'd0);

    xact(0, 0, 32'h103, 2'd0, 0, 0, 32'h8000_0000, 0);
    chk("lbs_data", res, 32'hFFFF_FF80);
    xact(0, 0, 32'h103, 2'd0, 1, 0, 32'h8000_0000, 0);
    chk("lbu_data", res, 32'h0000_0080);
    xact(0, 0, 32'h102, 2'd1, 0, 0, 32'h8001_0000, 1);
    chk("lhs_data", res, 32'hFFFF_8001);
    chk("lhs_lat", 32'(lat), 32'd3);

    xact(0, 1, 32'h202, 2'd1, 0, 32'h1234_ABCD, 32'hFFFF_FFFF, 3);
    chk("sh_addr", ma, 32'h200);
    chk("sh_strb", 32'(sb), 32'hC);
    chk("sh_wdata", mw, 32'hABCD_ABCD);
    chk("sh_vcnt", 32'(vc), 32'd4);
    chk("sh_lat", 32'(lat), 32'd5);
    chk("sh_rdata", res, 32'd0);
    chk("sh_err", 32'(err), 32'd0);

    xact(0, 1, 32'h201, 2'd0, 0, 32'h0000_0055, 0, 0);
    chk("sb_strb", 32'(sb), 32'h2);
    chk("sb_wdata", mw, 32'h5555_5555);

    xact(0, 0, 32'h101, 2'd3, 0, 0, 0, 0);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_vcnt", 32'(vc), 32'd0);
    xact(0, 0, 32'h100, 2'd2, 0, 0, 0, 0);
    chk("len2_lat", 32'(lat), 32'd1);
    chk("len2_err", 32'(err), 32'd1);
    chk("len2_vcnt", 32'(vc), 32'd0);
    xact(0, 1, 32'h103, 2'd1, 0, 0, 0, 0);
    chk("mish_err", 32'(err), 32'd1);

    // Simultaneous requests: data first, fetch after data's DONE.
    data_req = 1'b1; data_store = 1'b0; data_addr = 32'h10;
    data_len = 2'd3; data_unsigned = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step;
    chk("arb_addr", mem_addr, 32'h10);
    step;
    chk("arb_dack", 32'({data_ack, fetch_ack}), 32'b10);
    chk("arb_ddata", data_rdata, 32'hDEAD_BEEF);
    data_req = 1'b0;
    mem_rdata = 32'h1357_9BDF;
    step;
    chk("arb_idle", 32'(mem_valid), 32'd0);
    step;
    chk("arb_fvalid", 32'(mem_valid), 32'd1);
    chk("arb_faddr", mem_addr, 32'h0);
    step;
    chk("arb_fack", 32'({data_ack, fetch_ack}), 32'b01);
    chk("arb_fdata", fetch_data, 32'h1357_9BDF);
    chk("arb_ferr", 32'(fetch_err), 32'd0);
    fetch_req = 1'b0;
    mem_ready = 1'b0;
    step;

    xact(1, 0, 32'h40, 2'd3, 0, 0, 32'h1111_1111, 99);
    chk("to_vcnt", 32'(vc), 32'd5);
    chk("to_lat", 32'(lat), 32'd6);
    chk("to_err", 32'(err), 32'd1);
    chk("to_data", res, 32'd0);

    // Async reset in the middle of a bus cycle.
    data_req = 1'b1; data_store = 1'b0; data_addr = 32'h300;
    data_len = 2'd3; mem_ready = 1'b0;
    step;
    chk("ar_valid", 32'(mem_valid), 32'd1);
    step;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_drop", 32'(mem_valid), 32'd0);
    data_req = 1'b0;
    #2;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (data_ack | fetch_ack | mem_valid) acks++;
    end
    chk("ar_noack", 32'(acks), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access unit that replaces the core's combinational memory-address/length muxing with a registered, handshaked bus master. It arbitrates between the instruction-fetch channel and the load/store data channel and drives a single ready/valid memory port with variable wait states. It performs byte-lane steering, sign/zero extension, alignment checking and a bus timeout. It sits between the core's fetch controller and frame logic on one side and system memory on the other.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of requests and `mem_addr`.
- `TIMEOUT_CYCLES`, 255, wait cycles with `mem_ready` low before the unit aborts; minimum 1.
- Data width is fixed at 32 bits (`DATA_WIDTH`); strobes are 4 bits.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_req`  in  1  fetch channel request (level).
- `fetch_addr`  in  ADDR_WIDTH  fetch byte address; always a word access.
- `fetch_ack`  out  1  one-cycle completion pulse for fetch.
- `fetch_data`  out  32  fetched instruction; valid while `fetch_ack`=1.
- `fetch_err`  out  1  fetch misaligned or timed out; valid with `fetch_ack`.
- `data_req`  in  1  data channel request (level).
- `data_store`  in  1  1=store, 0=load.
- `data_addr`  in  ADDR_WIDTH  data byte address.
- `data_len`  in  2  bytes-1: 0=byte, 1=half, 3=word; 2 is illegal.
- `data_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `data_wdata`  in  32  store data, right-justified.
- `data_ack`  out  1  one-cycle completion pulse for data.
- `data_rdata`  out  32  extended load result; valid with `data_ack`; 0 for stores.
- `data_err`  out  1  misaligned, illegal length or timeout; valid with `data_ack`.
- `mem_valid`  out  1  bus request valid.
- `mem_write`  out  1  bus write.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, `{addr[ADDR_WIDTH-1:2],2'b00}`.
- `mem_wstrb`  out  4  byte-lane write strobes; 0 on reads.
- `mem_wdata`  out  32  lane-shifted store data.
- `mem_ready`  in  1  bus completes the transfer in this cycle.
- `mem_rdata`  in  32  read data; sampled when `mem_valid`&&`mem_ready`.

## Operation
- The state machine has the states IDLE, BUS, DONE.
- **IDLE**
  - If `data_req`=1, latch the data request; the data channel has priority. Otherwise, if `fetch_req`=1, latch the fetch request.
  - Alignment check on the latched request:
    - Half access requires `addr[0]`=0.
    - Word access and fetch require `addr[1:0]`=0.
    - `data_len`=2 is illegal.
  - On a check failure, go to DONE with err=1 and issue no bus cycle. Otherwise, go to BUS.
- **BUS**
  - `mem_valid`=1. Address, write, strobe and wdata are registered and stable until the state is left.
  - The timeout counter starts at 0 and increments each cycle with `mem_ready`=0.
  - `mem_ready`=1: capture and extend the read data, then go to DONE with err=0.
  - Counter equals `TIMEOUT_CYCLES`: go to DONE with err=1 and result 0.
- **DONE**
  - Pulse the ack of the owning channel for exactly one cycle, with result and err. Then go to IDLE.
  - Requests are ignored in DONE. The requester must deassert req in the ack cycle; a req still high in IDLE starts a new transaction.
- **Lane rules**, with lane = `addr[1:0]`:
  - Byte: strobe = `4'b0001<<lane`; wdata = `{4{wdata[7:0]}}`.
  - Half: strobe = `4'b0011<<lane`; wdata = `{2{wdata[15:0]}}`.
  - Word: strobe = `4'hF`.
  - Loads extract `mem_rdata >> (8*lane)`, then zero- or sign-extend from bit 7 or bit 15.
  - Fetch returns `mem_rdata` unmodified.
- Transactions are never interleaved. The losing channel waits with req held until it is served.

## Timing
- Reset (async) drives: state=IDLE, `mem_valid`=0, `mem_write`=0, `mem_addr`=0, `mem_wstrb`=0, `mem_wdata`=0, both acks=0, both errs=0, `fetch_data`=0, `data_rdata`=0, and clears the counter.
- Reset during BUS drops `mem_valid` immediately, and no ack is ever issued for that request.
- Req sampled at edge N:
  - `mem_valid` goes high after edge N.
  - If `mem_ready`=1 in that first BUS cycle, ack is high in cycle N+2.
  - Minimum latency is 2 cycles; each wait cycle adds 1.
- Misaligned or illegal request sampled at edge N: ack with err in cycle N+1, and `mem_valid` stays 0.
- Timeout: `mem_valid` is high for `TIMEOUT_CYCLES`+1 cycles, then ack with err in the following cycle.
- Simultaneous `fetch_req` and `data_req` in IDLE: data is served first. Fetch is accepted on the IDLE cycle after data's DONE, provided `data_req` has been dropped.

## Test plan
- Word load: `data_addr`=0x100, `mem_ready` tied 1, `mem_rdata`=0x8765_4321 → `mem_addr`=0x100, `mem_wstrb`=0, `data_ack` 2 cycles after req, `data_rdata`=0x8765_4321, `data_err`=0.
- Byte load at lane 3: `mem_rdata`=0x8000_0000, `data_unsigned`=0 → `data_rdata`=0xFFFF_FF80; repeat with `data_unsigned`=1 → `data_rdata`=0x0000_0080.
- Half store: `data_addr`=0x202, `data_wdata`=0x1234_ABCD, 3 wait cycles → `mem_addr`=0x200, `mem_wstrb`=4'b1100, `mem_wdata`=0xABCD_ABCD, `mem_valid` high 4 cycles, single `data_ack`.
- Misaligned word (`data_addr`=0x101) and `data_len`=2 → `data_ack` with `data_err`=1 one cycle after req, and `mem_valid` never asserted.
- Both reqs at once → data transaction completes first, then fetch at 0x0 returns `mem_rdata` unmodified on `fetch_ack`.
- `TIMEOUT_CYCLES`=4, `mem_ready`=0 → `mem_valid` high 5 cycles, then `fetch_err`=1 with `fetch_data`=0.
- Async reset asserted mid-BUS → `mem_valid` goes to 0 without a clock edge, and no ack appears after reset is released.
